id_ex_reg: RTL

- ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the hazard/redirect unit and consumes that unit's operand-bypass selects and bubble/flush requests.
- It selects forwarded operands for rs, rt, $v0 and $a0 (the syscall operands). It registers them together with the decoded control word for the EX stage.
- It inserts NOP bubbles on load-use and branch/jump flush. It returns a registered "current EX entry is a flush bubble" flag to the hazard unit.

---
 rtl/mips_pipe_pkg.sv | 43 ++++
 rtl/id_ex_reg_if.sv | 57 +++++
 rtl/fwd_mux4.sv | 24 ++
 rtl/id_ex_reg.sv | 94 +++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: widths, bypass select codes, control-word layout
// and the ID/EX register entry.
package mips_pipe_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    localparam logic [1:0] BYP_RF    = 2'b00;
    localparam logic [1:0] BYP_EXMEM = 2'b01;
    localparam logic [1:0] BYP_WB    = 2'b10;
    localparam logic [1:0] BYP_LD    = 2'b11;

    // Control-word bit positions; ALU op and spare bits occupy the upper field.
    localparam int unsigned CTRL_REGW     = 0;
    localparam int unsigned CTRL_MEMR     = 1;
    localparam int unsigned CTRL_MEMW     = 2;
    localparam int unsigned CTRL_BRANCH   = 3;
    localparam int unsigned CTRL_JUMP     = 4;
    localparam int unsigned CTRL_JMPREG   = 5;
    localparam int unsigned CTRL_SYSCALL  = 6;
    localparam int unsigned CTRL_ALUOP_LO = 7;

    localparam logic [CW-1:0] CTRL_NOP = '0;

    localparam logic [AW-1:0] REG_V0 = 5'd2;
    localparam logic [AW-1:0] REG_A0 = 5'd4;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] ir;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
        logic [AW-1:0] rw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] v0;
        logic [DW-1:0] a0;
        logic          bf;
    } ex_entry_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX register port bundle: ID-side inputs, bypass sources, EX-side outputs.
// Perf-counter signals exist only when IDEX_PERF_CNT_EN is defined.
interface id_ex_reg_if;
    import mips_pipe_pkg::*;

    logic          stall;
    logic          bubble;
    logic          flush_br;
    logic          flush_j;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_ir;
    logic [CW-1:0] id_ctrl;
    logic [AW-1:0] id_rw;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] rf_a, rf_b, rf_v0, rf_a0;
    logic [1:0]    byp_a, byp_b, byp_v0, byp_a0;
    logic [DW-1:0] exmem_alu;
    logic [DW-1:0] memwb_wdata;
    logic [DW-1:0] memwb_ldata;
    logic          ex_valid;
    logic [DW-1:0] ex_pc, ex_ir, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [AW-1:0] ex_rw;
    logic [DW-1:0] ex_a, ex_b, ex_v0, ex_a0;
    logic          bubble_f_new;
`ifdef IDEX_PERF_CNT_EN
    logic          perf_clr;
    logic [DW-1:0] perf_bubbles;
    logic [DW-1:0] perf_flushes;
`endif

    modport slave (
        input  stall, bubble, flush_br, flush_j, id_valid, id_pc, id_ir, id_ctrl, id_rw, id_imm,
        input  rf_a, rf_b, rf_v0, rf_a0, byp_a, byp_b, byp_v0, byp_a0,
        input  exmem_alu, memwb_wdata, memwb_ldata,
`ifdef IDEX_PERF_CNT_EN
        input  perf_clr,
        output perf_bubbles, perf_flushes,
`endif
        output ex_valid, ex_pc, ex_ir, ex_imm, ex_ctrl, ex_rw,
        output ex_a, ex_b, ex_v0, ex_a0, bubble_f_new
    );

    modport master (
        output stall, bubble, flush_br, flush_j, id_valid, id_pc, id_ir, id_ctrl, id_rw, id_imm,
        output rf_a, rf_b, rf_v0, rf_a0, byp_a, byp_b, byp_v0, byp_a0,
        output exmem_alu, memwb_wdata, memwb_ldata,
`ifdef IDEX_PERF_CNT_EN
        output perf_clr,
        input  perf_bubbles, perf_flushes,
`endif
        input  ex_valid, ex_pc, ex_ir, ex_imm, ex_ctrl, ex_rw,
        input  ex_a, ex_b, ex_v0, ex_a0, bubble_f_new
    );

endinterface

// File: rtl/fwd_mux4.sv
// DW-wide 4:1 operand bypass mux: register file, EX/MEM ALU, MEM/WB data, MEM/WB load.
module fwd_mux4
    import mips_pipe_pkg::*;
(
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_rf,
    input  logic [DW-1:0] i_exmem,
    input  logic [DW-1:0] i_wb,
    input  logic [DW-1:0] i_ld,
    output logic [DW-1:0] o_y_c
);

    always_comb begin
        o_y_c = i_rf;
        unique case (i_sel)
            BYP_RF:    o_y_c = i_rf;
            BYP_EXMEM: o_y_c = i_exmem;
            BYP_WB:    o_y_c = i_wb;
            BYP_LD:    o_y_c = i_ld;
            default:   o_y_c = i_rf;
        endcase
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding, NOP bubble/flush insertion and a
// branch-flush marker. Define IDEX_PERF_CNT_EN to add bubble/flush perf counters.
module id_ex_reg
    import mips_pipe_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    id_ex_reg_if.slave bus
);

    logic [DW-1:0] w_a, w_b, w_v0, w_a0;
    logic          w_we;
    logic          w_flush;
    logic          w_clr;
    ex_entry_t     w_ex_nxt;
    ex_entry_t     r_ex;

    fwd_mux4 u_fwd_a (.i_sel(bus.byp_a), .i_rf(bus.rf_a), .i_exmem(bus.exmem_alu),
                      .i_wb(bus.memwb_wdata), .i_ld(bus.memwb_ldata), .o_y_c(w_a));
    fwd_mux4 u_fwd_b (.i_sel(bus.byp_b), .i_rf(bus.rf_b), .i_exmem(bus.exmem_alu),
                      .i_wb(bus.memwb_wdata), .i_ld(bus.memwb_ldata), .o_y_c(w_b));
    fwd_mux4 u_fwd_v0 (.i_sel(bus.byp_v0), .i_rf(bus.rf_v0), .i_exmem(bus.exmem_alu),
                       .i_wb(bus.memwb_wdata), .i_ld(bus.memwb_ldata), .o_y_c(w_v0));
    fwd_mux4 u_fwd_a0 (.i_sel(bus.byp_a0), .i_rf(bus.rf_a0), .i_exmem(bus.exmem_alu),
                       .i_wb(bus.memwb_wdata), .i_ld(bus.memwb_ldata), .o_y_c(w_a0));

    // Shared enable/clear: flush outranks bubble, stall outranks both.
    assign w_we    = !bus.stall;
    assign w_flush = bus.flush_br | bus.flush_j;
    assign w_clr   = w_flush | bus.bubble;

    always_comb begin
        w_ex_nxt    = '0;
        w_ex_nxt.pc = bus.id_pc;
        w_ex_nxt.bf = bus.flush_br;
        if (!w_clr) begin
            w_ex_nxt.valid = bus.id_valid;
            w_ex_nxt.ir    = bus.id_ir;
            w_ex_nxt.imm   = bus.id_imm;
            w_ex_nxt.ctrl  = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
            w_ex_nxt.rw    = bus.id_rw;
            w_ex_nxt.a     = w_a;
            w_ex_nxt.b     = w_b;
            w_ex_nxt.v0    = w_v0;
            w_ex_nxt.a0    = w_a0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (w_we) begin
            r_ex <= w_ex_nxt;
        end
    end

    assign bus.ex_valid     = r_ex.valid;
    assign bus.ex_pc        = r_ex.pc;
    assign bus.ex_ir        = r_ex.ir;
    assign bus.ex_imm       = r_ex.imm;
    assign bus.ex_ctrl      = r_ex.ctrl;
    assign bus.ex_rw        = r_ex.rw;
    assign bus.ex_a         = r_ex.a;
    assign bus.ex_b         = r_ex.b;
    assign bus.ex_v0        = r_ex.v0;
    assign bus.ex_a0        = r_ex.a0;
    assign bus.bubble_f_new = r_ex.bf;

`ifdef IDEX_PERF_CNT_EN
    logic [DW-1:0] r_perf_bubbles;
    logic [DW-1:0] r_perf_flushes;

    // Saturating NOP-insertion counters; a bubble hidden by a flush is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bubbles <= '0;
            r_perf_flushes <= '0;
        end else if (bus.perf_clr) begin
            r_perf_bubbles <= '0;
            r_perf_flushes <= '0;
        end else if (w_we) begin
            if (w_flush) begin
                if (r_perf_flushes != '1) r_perf_flushes <= r_perf_flushes + DW'(1);
            end else if (bus.bubble) begin
                if (r_perf_bubbles != '1) r_perf_bubbles <= r_perf_bubbles + DW'(1);
            end
        end
    end

    assign bus.perf_bubbles = r_perf_bubbles;
    assign bus.perf_flushes = r_perf_flushes;
`endif

endmodule
